// File: rtl/guess_judge_pkg.sv
// Shared types and constants for the number-guessing judge.
// Holds the FSM state encoding, hint codes and game sizing.
package guess_pkg;

  localparam int         NUM_W     = 4;
  localparam logic [1:0] LIFE_INIT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_CHECK = 3'd2,
    ST_WON   = 3'd3,
    ST_LOST  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    HINT_NONE = 2'b00,
    HINT_LOW  = 2'b01,
    HINT_HIGH = 2'b10
  } hint_t;

  // Direction hint for a wrong guess, unsigned compare.
  function automatic hint_t miss_hint(input logic [NUM_W-1:0] g, input logic [NUM_W-1:0] s);
    return (g < s) ? HINT_LOW : HINT_HIGH;
  endfunction

endpackage

// File: rtl/guess_judge_if.sv
// Player-side signal bundle of one guess judge.
// master drives the secret/guess controls, slave is the judge.
interface guess_judge_if;
  import guess_pkg::*;

  logic             load_secret;
  logic [NUM_W-1:0] secret_in;
  logic             play;
  logic [NUM_W-1:0] guess;
  logic             bingo;
  logic [1:0]       lifeOut;
  logic [1:0]       hint;
  logic             done;

  modport master (
    output load_secret, secret_in, play, guess,
    input  bingo, lifeOut, hint, done
  );

  modport slave (
    input  load_secret, secret_in, play, guess,
    output bingo, lifeOut, hint, done
  );

endinterface

// File: rtl/guess_judge_lfsr4.sv
// Free-running 4-bit maximal-length LFSR, x^4+x^3+1, seeded 4'b1001.
// Period 15, never reaches zero.
module lfsr4 (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= 4'b1001;
    else       q <= {q[2:0], q[3] ^ q[2]};
  end

endmodule

// File: rtl/guess_judge.sv
// One player's judge: latches a secret, grades edge-triggered guesses, 3 lives.
// SECRET_LFSR_EN: take the secret from an internal LFSR instead of secret_in.
module guess_judge
  import guess_pkg::*;
(
  input  logic clk,
  input  logic reset,
  guess_judge_if.slave gif
);

  state_t           state, state_nx;
  logic             play_d;
  logic [NUM_W-1:0] secret, secret_nx;
  logic [NUM_W-1:0] guess_q, guess_q_nx;
  logic [NUM_W-1:0] load_val;
  logic             bingo_nx, done_nx;
  logic [1:0]       life_nx, hint_nx;
  logic             play_evt;

`ifdef SECRET_LFSR_EN
  logic [NUM_W-1:0] lfsr_q;
  logic             unused_secret_in;

  lfsr4 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign load_val         = lfsr_q;
  assign unused_secret_in = ^gif.secret_in;
`else
  assign load_val = gif.secret_in;
`endif

  // Only a rising edge of play is a guess; holding play does nothing more.
  assign play_evt = gif.play & ~play_d;

  always_comb begin
    state_nx   = state;
    secret_nx  = secret;
    guess_q_nx = guess_q;
    bingo_nx   = gif.bingo;
    life_nx    = gif.lifeOut;
    hint_nx    = gif.hint;
    done_nx    = gif.done;
    case (state)
      ST_IDLE: begin
        if (gif.load_secret) begin
          secret_nx = load_val;
          state_nx  = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (play_evt) begin
          guess_q_nx = gif.guess;
          state_nx   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (guess_q == secret) begin
          bingo_nx = 1'b1;
          hint_nx  = HINT_NONE;
          done_nx  = 1'b1;
          state_nx = ST_WON;
        end else begin
          hint_nx = miss_hint(guess_q, secret);
          life_nx = (gif.lifeOut == 2'd0) ? 2'd0 : gif.lifeOut - 2'd1;
          if (gif.lifeOut <= 2'd1) begin
            done_nx  = 1'b1;
            state_nx = ST_LOST;
          end else begin
            state_nx = ST_ARMED;
          end
        end
      end
      default: ; // WON / LOST hold everything until reset
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      play_d      <= 1'b0;
      secret      <= '0;
      guess_q     <= '0;
      gif.bingo   <= 1'b0;
      gif.lifeOut <= LIFE_INIT;
      gif.hint    <= HINT_NONE;
      gif.done    <= 1'b0;
    end else begin
      state       <= state_nx;
      play_d      <= gif.play;
      secret      <= secret_nx;
      guess_q     <= guess_q_nx;
      gif.bingo   <= bingo_nx;
      gif.lifeOut <= life_nx;
      gif.hint    <= hint_nx;
      gif.done    <= done_nx;
    end
  end

endmodule
